// File: rtl/mmio_io_ctrl_pkg.sv
// mmio_io_ctrl_pkg
// Shared definitions for the memory-mapped I/O slave:
//   - byte addresses of the six I/O registers
//   - widths of the HEX/LEDR/LEDG/KEY/SW registers
//   - key debounce state encoding
//   - isIoAddr(): exact 32-bit address match against the I/O map
package mmio_io_ctrl_pkg;

  localparam logic [31:0] ADDR_HEX     = 32'hF000_0000;
  localparam logic [31:0] ADDR_LEDR    = 32'hF000_0004;
  localparam logic [31:0] ADDR_LEDG    = 32'hF000_0008;
  localparam logic [31:0] ADDR_KEY     = 32'hF000_0010;
  localparam logic [31:0] ADDR_SW      = 32'hF000_0014;
  localparam logic [31:0] ADDR_KEYEDGE = 32'hF000_0018;

  localparam int HEX_W  = 16;
  localparam int LEDR_W = 10;
  localparam int LEDG_W = 8;
  localparam int KEY_W  = 4;
  localparam int SW_W   = 10;

  typedef enum logic {
    STABLE   = 1'b0,
    CHANGING = 1'b1
  } debState_t;

  function automatic logic isIoAddr(input logic [31:0] a);
    return (a == ADDR_HEX)  || (a == ADDR_LEDR) || (a == ADDR_LEDG) ||
           (a == ADDR_KEY)  || (a == ADDR_SW)   || (a == ADDR_KEYEDGE);
  endfunction

endpackage

// File: rtl/mmio_io_ctrl_if.sv
// mmio_io_ctrl_if
// Memory-stage bus between the pipeline register (master) and the I/O
// slave. The slave answers reads combinationally in the same cycle.
//   addr   byte address            (master -> slave)
//   wrtEn  store enable            (master -> slave)
//   dIn    store data              (master -> slave)
//   dOut   read data, zero-extended (slave -> master)
//   isIo   addr hits the I/O map   (slave -> master)
interface mmio_io_ctrl_if;
  logic [31:0] addr;
  logic        wrtEn;
  logic [31:0] dIn;
  logic [31:0] dOut;
  logic        isIo;

  modport master (output addr, wrtEn, dIn, input dOut, isIo);
  modport slave  (input addr, wrtEn, dIn, output dOut, isIo);
endinterface

// File: rtl/mmio_io_ctrl_debounce.sv
// io_debounce
// One key bit: two-flop synchroniser followed by an optional debouncer.
// Macro MMIO_KEY_DEBOUNCE_EN selects the debouncer; without it the
// synchronised level is used directly and the parameters are unused.
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   rawIn        raw board key (0 = pressed)
//   stableOut    accepted key level (resets to 1 = released)
//   pressPulse   high in the cycle whose clk edge makes stableOut fall
//
// state    | meaning
// ---------+-----------------------------------------------------------
// STABLE   | synchronised input equals accepted level, counter held at 0
// CHANGING | input differs; counting cycles it has held the new level
module io_debounce
  import mmio_io_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_BITS        = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic rawIn,
  output logic stableOut,
  output logic pressPulse
);

  logic sync1;
  logic sync2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rawIn;
      sync2 <= sync1;
    end
  end

`ifdef MMIO_KEY_DEBOUNCE_EN
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  debState_t            state;
  logic [CNT_BITS-1:0]  count;
  logic                 stable;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= STABLE;
      count  <= '0;
      stable <= 1'b1;
    end else begin
      case (state)
        STABLE: begin
          if (sync2 != stable) begin
            state <= CHANGING;
            count <= CNT_BITS'(1);
          end else begin
            count <= '0;
          end
        end
        CHANGING: begin
          if (sync2 == stable) begin
            state <= STABLE;
            count <= '0;
          end else if (count == CNT_LAST) begin
            stable <= sync2;
            state  <= STABLE;
            count  <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state <= STABLE;
          count <= '0;
        end
      endcase
    end
  end

  assign stableOut = stable;
  // Acceptance of a new low level while the accepted level is still high.
  assign pressPulse = (state == CHANGING) && (sync2 != stable) &&
                      (count == CNT_LAST) && stable;
`else
  assign stableOut  = sync2;
  // sync2 takes sync1 at the next edge, so this flags the falling edge.
  assign pressPulse = sync2 && !sync1;

  // Parameters stay in the port list so both builds share one interface;
  // this check keeps them referenced and elaborates to nothing.
  if ((2 ** CNT_BITS) <= DEBOUNCE_CYCLES) begin : gCntTooNarrow
  end
`endif

endmodule

// File: rtl/mmio_io_ctrl.sv
// mmio_io_ctrl
// Memory-mapped I/O slave in the memory stage. Owns the HEX/LEDR/LEDG
// output registers, synchronises SW, synchronises/debounces KEY and keeps
// sticky key-press flags (write-1-to-clear). Reads are combinational.
// Optional debounce via macro MMIO_KEY_DEBOUNCE_EN.
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   bus          mmio_io_ctrl_if.slave (addr, wrtEn, dIn, dOut, isIo)
//   key[3:0]     raw keys, 0 = pressed
//   sw[9:0]      raw switches
//   hex, ledr, ledg  output registers
module mmio_io_ctrl
  import mmio_io_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_BITS        = 20
) (
  input  logic              clk,
  input  logic              reset,
  mmio_io_ctrl_if.slave     bus,
  input  logic [KEY_W-1:0]  key,
  input  logic [SW_W-1:0]   sw,
  output logic [HEX_W-1:0]  hex,
  output logic [LEDR_W-1:0] ledr,
  output logic [LEDG_W-1:0] ledg
);

  logic [SW_W-1:0]  swMeta;
  logic [SW_W-1:0]  swSync;
  logic [KEY_W-1:0] keyStable;
  logic [KEY_W-1:0] keyPress;
  logic [KEY_W-1:0] keyEdge;
  logic [KEY_W-1:0] edgeClr;

  // Only the low bits of store data reach any register.
  wire unusedDinHi = ^bus.dIn[31:HEX_W];

  for (genvar i = 0; i < KEY_W; i++) begin : gKey
    io_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_BITS        (CNT_BITS)
    ) uDeb (
      .clk        (clk),
      .reset      (reset),
      .rawIn      (key[i]),
      .stableOut  (keyStable[i]),
      .pressPulse (keyPress[i])
    );
  end

  assign edgeClr = (bus.wrtEn && (bus.addr == ADDR_KEYEDGE)) ?
                   bus.dIn[KEY_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      swMeta  <= '0;
      swSync  <= '0;
      hex     <= '0;
      ledr    <= '0;
      ledg    <= '0;
      keyEdge <= '0;
    end else begin
      swMeta <= sw;
      swSync <= swMeta;
      if (bus.wrtEn) begin
        case (bus.addr)
          ADDR_HEX:  hex  <= bus.dIn[HEX_W-1:0];
          ADDR_LEDR: ledr <= bus.dIn[LEDR_W-1:0];
          ADDR_LEDG: ledg <= bus.dIn[LEDG_W-1:0];
          default: ;
        endcase
      end
      // A press in the same cycle as a clear keeps the flag set.
      keyEdge <= (keyEdge & ~edgeClr) | keyPress;
    end
  end

  always_comb begin
    bus.dOut = '0;
    case (bus.addr)
      ADDR_HEX:     bus.dOut = 32'(hex);
      ADDR_LEDR:    bus.dOut = 32'(ledr);
      ADDR_LEDG:    bus.dOut = 32'(ledg);
      ADDR_KEY:     bus.dOut = 32'(keyStable);
      ADDR_SW:      bus.dOut = 32'(swSync);
      ADDR_KEYEDGE: bus.dOut = 32'(keyEdge);
      default:      bus.dOut = '0;
    endcase
  end

  assign bus.isIo = isIoAddr(bus.addr);

endmodule

// File: tb/tb_mmio_io_ctrl.sv
module tb_mmio_io_ctrl;
  import mmio_io_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key;
  logic [9:0] sw;
  logic [15:0] hex;
  logic [9:0]  ledr;
  logic [7:0]  ledg;

  int errors = 0;
  int checks = 0;

`ifdef MMIO_KEY_DEBOUNCE_EN
  localparam int KeyLat = 2 + 4;
  localparam logic [31:0] EdgeAfterGlitch = 32'h4;
`else
  localparam int KeyLat = 2;
  localparam logic [31:0] EdgeAfterGlitch = 32'h6;
`endif

  mmio_io_ctrl_if bus ();

  mmio_io_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .CNT_BITS        (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .key   (key),
    .sw    (sw),
    .hex   (hex),
    .ledr  (ledr),
    .ledg  (ledg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] expDout;
    logic        expIo;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic readCheck(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.wrtEn = 1'b0;
    bus.addr  = a;
    #1;
    check(name, bus.dOut, exp);
  endtask

  task automatic writeReg(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.dIn   = d;
    bus.wrtEn = 1'b1;
    tick();
    bus.wrtEn = 1'b0;
    bus.dIn   = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{"rd_hex",      1'b0, ADDR_HEX,      32'h0,         32'h0,        1'b1};
    vecs[1]  = '{"rd_ledr",     1'b0, ADDR_LEDR,     32'h0,         32'h0,        1'b1};
    vecs[2]  = '{"rd_ledg",     1'b0, ADDR_LEDG,     32'h0,         32'h0,        1'b1};
    vecs[3]  = '{"rd_key",      1'b0, ADDR_KEY,      32'h0,         32'hF,        1'b1};
    vecs[4]  = '{"rd_sw",       1'b0, ADDR_SW,       32'h0,         32'h0,        1'b1};
    vecs[5]  = '{"rd_keyedge",  1'b0, ADDR_KEYEDGE,  32'h0,         32'h0,        1'b1};
    vecs[6]  = '{"rd_gap",      1'b0, 32'hF000000C,  32'h0,         32'h0,        1'b0};
    vecs[7]  = '{"rd_misalign", 1'b0, 32'hF0000001,  32'h0,         32'h0,        1'b0};
    vecs[8]  = '{"wr_hex",      1'b1, ADDR_HEX,      32'hFFFF1234,  32'h00001234, 1'b1};
    vecs[9]  = '{"wr_ledr",     1'b1, ADDR_LEDR,     32'hFFFFFFFF,  32'h000003FF, 1'b1};
    vecs[10] = '{"wr_ledg",     1'b1, ADDR_LEDG,     32'h000001A5,  32'h000000A5, 1'b1};
    vecs[11] = '{"wr_key_ro",   1'b1, ADDR_KEY,      32'h00000000,  32'h0000000F, 1'b1};
    vecs[12] = '{"wr_unmapped", 1'b1, 32'hF000001C,  32'h0000FFFF,  32'h0,        1'b0};

    reset     = 1'b0;
    key       = 4'hF;
    sw        = '0;
    bus.addr  = '0;
    bus.dIn   = '0;
    bus.wrtEn = 1'b0;
    tick(3);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) writeReg(vecs[i].addr, vecs[i].din);
      readCheck(vecs[i].name, vecs[i].addr, vecs[i].expDout);
      check({vecs[i].name, "_isio"}, 32'(bus.isIo), 32'(vecs[i].expIo));
    end
    check("port_hex",  32'(hex),  32'h1234);
    check("port_ledr", 32'(ledr), 32'h3FF);
    check("port_ledg", 32'(ledg), 32'hA5);

    // Press and hold key[2].
    key = 4'hB;
    tick(KeyLat - 1);
    readCheck("key_before_lat", ADDR_KEY, 32'hF);
    tick();
    readCheck("key_pressed", ADDR_KEY, 32'hB);
    readCheck("edge_pressed", ADDR_KEYEDGE, 32'h4);

    // Release: flag is sticky, release sets nothing.
    key = 4'hF;
    tick(KeyLat + 2);
    readCheck("key_released", ADDR_KEY, 32'hF);
    readCheck("edge_after_release", ADDR_KEYEDGE, 32'h4);

    // Two-cycle glitch on key[1].
    key = 4'hD;
    tick(2);
    key = 4'hF;
    tick(8);
    readCheck("key_after_glitch", ADDR_KEY, 32'hF);
    readCheck("edge_after_glitch", ADDR_KEYEDGE, EdgeAfterGlitch);
    writeReg(ADDR_KEYEDGE, 32'h2);
    readCheck("edge_clr_bit1", ADDR_KEYEDGE, 32'h4);

    // Clear of bit 2 in the very cycle a new key[2] press is accepted.
    key = 4'hB;
    tick(KeyLat - 1);
    writeReg(ADDR_KEYEDGE, 32'h4);
    readCheck("edge_set_wins", ADDR_KEYEDGE, 32'h4);
    readCheck("key_repressed", ADDR_KEY, 32'hB);
    key = 4'hF;
    writeReg(ADDR_KEYEDGE, 32'h4);
    readCheck("edge_cleared", ADDR_KEYEDGE, 32'h0);
    tick(KeyLat + 2);
    readCheck("edge_release_quiet", ADDR_KEYEDGE, 32'h0);

    // Switch synchroniser latency.
    sw = 10'h2A5;
    tick();
    readCheck("sw_lat1", ADDR_SW, 32'h0);
    tick();
    readCheck("sw_lat2", ADDR_SW, 32'h000002A5);
    writeReg(ADDR_SW, 32'h0);
    readCheck("sw_wr_ignored", ADDR_SW, 32'h000002A5);

    // Reset in the middle of a key[0] debounce.
    key = 4'hE;
    tick(3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    readCheck("rst_key", ADDR_KEY, 32'hF);
    readCheck("rst_edge", ADDR_KEYEDGE, 32'h0);
    readCheck("rst_sw", ADDR_SW, 32'h0);
    check("rst_hex", 32'(hex), 32'h0);
    check("rst_ledr", 32'(ledr), 32'h0);
    key = 4'hF;
    tick(10);
    readCheck("rst_edge_later", ADDR_KEYEDGE, 32'h0);
    readCheck("rst_key_later", ADDR_KEY, 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mmio_io_ctrl.md
Name: mmio_io_ctrl

Overview:
- Memory-mapped I/O slave in the memory stage, directly downstream of the pipeline register.
- Consumes the registered store/load address, store data and write enable alongside data memory.
- Owns the HEX/LEDR/LEDG output registers, synchronises SW, and debounces KEY with sticky press flags.
- Read data is combinational from registered state, so the writeback mux sees it in the same cycle.

Parameters:
- ADDR_HEX, 32'hF0000000, HEX display register (16 bits)
- ADDR_LEDR, 32'hF0000004, red LED register (10 bits)
- ADDR_LEDG, 32'hF0000008, green LED register (8 bits)
- ADDR_KEY, 32'hF0000010, debounced KEY level, read-only
- ADDR_SW, 32'hF0000014, synchronised SW level, read-only
- ADDR_KEYEDGE, 32'hF0000018, sticky key-press flags, write-1-to-clear
- DEBOUNCE_CYCLES, 500000, cycles an input must hold stable before acceptance (10 ms at 50 MHz)
- CNT_BITS, 20, debounce counter width; must satisfy 2^CNT_BITS > DEBOUNCE_CYCLES

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on the rising edge of clk)
- addr  in  32  byte address from pipeline register
- wrtEn  in  1  store enable from pipeline register
- dIn  in  32  store data
- key  in  4  raw board keys; 0 = pressed
- sw  in  10  raw board switches
- dOut  out  32  read data, zero-extended
- isIo  out  1  addr hits any of the six I/O addresses (combinational)
- hex  out  16  HEX display value
- ledr  out  10  red LEDs
- ledg  out  8  green LEDs

Behaviour:
- Reset (reset==0 at a clk edge) sets:
  - hex=0, ledr=0, ledg=0, keyEdge=0
  - keyStable=4'hF, keySync=4'hF, swSync=0
  - all debounce counters 0
- Reset asserted mid-debounce discards progress; no edge flag is set.
- Synchronisers: key and sw each pass through 2 flops. swSync is the SW read value, so SW latency is 2 cycles.
- Debounce, per key bit, states STABLE/CHANGING:
  - STABLE: while sync==stable, count=0. When sync!=stable, go to CHANGING with count=1.
  - CHANGING: if sync==stable, go to STABLE with count=0 (glitch rejected).
  - CHANGING: else if count==DEBOUNCE_CYCLES-1, stable<=sync, go to STABLE, count=0.
  - CHANGING: else count++.
- Edge capture: a 1->0 transition of keyStable[i] (press) sets keyEdge[i]. Release sets nothing.
- Writes take effect at the clk edge when wrtEn=1; readback shows the new value the cycle after.
  - ADDR_HEX: hex<=dIn[15:0]
  - ADDR_LEDR: ledr<=dIn[9:0]
  - ADDR_LEDG: ledg<=dIn[7:0]
  - ADDR_KEYEDGE: keyEdge <= keyEdge & ~dIn[3:0]
  - Upper data bits are ignored.
  - Writes to ADDR_KEY, ADDR_SW or any non-matching address are ignored.
- Same-cycle clear and new press on the same bit: set wins, flag stays 1.
- Reads (combinational, any cycle):
  - dOut = zero-extended register selected by addr.
  - Unmatched address: dOut=0, isIo=0.
  - Reads have no side effects.
- Address match uses all 32 bits exactly; addr[1:0] must be 0 to match.

Optional Feature:
- Macro: MMIO_KEY_DEBOUNCE_EN.
- Defined: debounce FSM as above.
- Undefined:
  - keyStable = keySync directly.
  - No counters, so KEY latency is 2 cycles.
  - Edge capture still operates on keySync.
  - DEBOUNCE_CYCLES and CNT_BITS are unused.

Decomposition:
- Shared package holds:
  - the six address constants
  - register widths (HEX 16, LEDR 10, LEDG 8, KEY 4, SW 10)
  - the debounce state enum {STABLE, CHANGING}
- One sub-module, io_debounce: 1-bit sync-plus-debounce with its own counter and a press-pulse output. Instantiated 4 times.

Test Plan (DEBOUNCE_CYCLES=4 for simulation):
- Release reset, then read every address:
  - dOut=0 for HEX/LEDR/LEDG/KEYEDGE/SW; dOut=32'hF for KEY.
  - addr=32'hF000000C gives dOut=0, isIo=0.
- Store 32'hFFFF1234 to HEX and 32'hFFFFFFFF to LEDR:
  - next cycle hex=16'h1234, ledr=10'h3FF.
  - readbacks return 32'h00001234 and 32'h000003FF.
- Drive key[2]=0 and hold:
  - KEY reads 32'hF until 2+4 cycles elapse, then 32'hB.
  - KEYEDGE reads 32'h4.
  - Releasing key[2] leaves KEYEDGE at 32'h4.
- Pulse key[1]=0 for 2 cycles only: KEY stays 32'hF, KEYEDGE unchanged (glitch rejected).
- With KEYEDGE=32'h4:
  - write 32'h4 to ADDR_KEYEDGE in the same cycle key[2] registers a new press → KEYEDGE stays 32'h4.
  - write 32'h4 with no press → 32'h0.
- Set sw=10'h2A5: SW reads 32'h000002A5 exactly 2 cycles later. Write to ADDR_SW is ignored.
